// File: rtl/button_debounce.sv
// button_debounce
// Debounces already-synchronized key levels and turns each physical press
// into exactly one press strobe, one release strobe, and (optionally) a
// train of auto-repeat strobes while the key stays held.
//
// Ports
//   Clk           : system clock, all state updates on the rising edge
//   Reset         : asynchronous, active-high; clears all channels
//   raw_in        : synchronized key levels, polarity set by ACTIVE_LOW
//   level_out     : debounced pressed state, 1 = pressed
//   press_pulse   : one-cycle strobe when level_out rises
//   release_pulse : one-cycle strobe when level_out falls
//   repeat_pulse  : one-cycle auto-repeat strobe while held
//
// Per-channel states
//   state             | meaning
//   S_RELEASED        | key accepted as released, level_out = 0
//   S_CONFIRM_PRESS   | counting agreeing pressed samples
//   S_HELD            | key accepted as pressed, repeat timer running
//   S_CONFIRM_RELEASE | counting agreeing released samples, level_out = 1

module button_debounce #(
   parameter int NUM_BTN       = 4,
   parameter int ACTIVE_LOW    = 1,
   parameter int STABLE_CYCLES = 50000,
   parameter int REPEAT_DELAY  = 0,
   parameter int REPEAT_PERIOD = 5000000
) (
   input  logic               Clk,
   input  logic               Reset,
   input  logic [NUM_BTN-1:0] raw_in,
   output logic [NUM_BTN-1:0] level_out,
   output logic [NUM_BTN-1:0] press_pulse,
   output logic [NUM_BTN-1:0] release_pulse,
   output logic [NUM_BTN-1:0] repeat_pulse
);

   localparam int STW     = $clog2(STABLE_CYCLES + 1);
   localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int RW      = $clog2(RPT_MAX + 1);

   localparam logic [STW-1:0] CNT_LAST = STW'(STABLE_CYCLES - 1);
   // Repeat timer is a down-counter: loaded so that it hits zero on the
   // edge that should emit the strobe, then reloaded with the period.
   localparam logic [RW-1:0]  RPT_FIRST  = (REPEAT_DELAY > 0) ? RW'(REPEAT_DELAY - 1) : '0;
   localparam logic [RW-1:0]  RPT_RELOAD = RW'(REPEAT_PERIOD - 1);
   localparam logic           POL        = (ACTIVE_LOW != 0);

   typedef enum logic [1:0] {
      S_RELEASED,
      S_CONFIRM_PRESS,
      S_HELD,
      S_CONFIRM_RELEASE
   } state_t;

   for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
      state_t         state_q, state_d;
      logic [STW-1:0] cnt_q, cnt_d;
      logic [RW-1:0]  rpt_q, rpt_d;
      logic           level_q, level_d;
      logic           press_q, press_d;
      logic           release_q, release_d;
      logic           repeat_q, repeat_d;
      logic           p;

      assign p = raw_in[i] ^ POL;

      always_comb begin
         state_d   = state_q;
         cnt_d     = cnt_q;
         rpt_d     = rpt_q;
         level_d   = level_q;
         press_d   = 1'b0;
         release_d = 1'b0;
         repeat_d  = 1'b0;
         case (state_q)
            S_RELEASED: begin
               level_d = 1'b0;
               if (p) begin
                  state_d = S_CONFIRM_PRESS;
                  cnt_d   = STW'(1);
               end else begin
                  cnt_d   = '0;
               end
            end
            S_CONFIRM_PRESS: begin
               if (!p) begin
                  state_d = S_RELEASED;
                  cnt_d   = '0;
               end else if (cnt_q == CNT_LAST) begin
                  state_d = S_HELD;
                  cnt_d   = '0;
                  rpt_d   = RPT_FIRST;
                  level_d = 1'b1;
                  press_d = 1'b1;
               end else begin
                  cnt_d   = cnt_q + STW'(1);
               end
            end
            S_HELD: begin
               level_d = 1'b1;
               if (!p) begin
                  state_d = S_CONFIRM_RELEASE;
                  cnt_d   = STW'(1);
               end else if (REPEAT_DELAY > 0) begin
                  if (rpt_q == '0) begin
                     repeat_d = 1'b1;
                     rpt_d    = RPT_RELOAD;
                  end else begin
                     rpt_d    = rpt_q - RW'(1);
                  end
               end
            end
            S_CONFIRM_RELEASE: begin
               // Repeat timer deliberately frozen here so a release glitch
               // does not restart the repeat cadence.
               level_d = 1'b1;
               if (p) begin
                  state_d = S_HELD;
                  cnt_d   = '0;
               end else if (cnt_q == CNT_LAST) begin
                  state_d   = S_RELEASED;
                  cnt_d     = '0;
                  level_d   = 1'b0;
                  release_d = 1'b1;
               end else begin
                  cnt_d     = cnt_q + STW'(1);
               end
            end
            default: begin
               state_d = S_RELEASED;
               cnt_d   = '0;
               level_d = 1'b0;
            end
         endcase
      end

      always_ff @(posedge Clk or posedge Reset) begin
         if (Reset) begin
            state_q   <= S_RELEASED;
            cnt_q     <= '0;
            rpt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            repeat_q  <= 1'b0;
         end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rpt_q     <= rpt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            repeat_q  <= repeat_d;
         end
      end

      assign level_out[i]     = level_q;
      assign press_pulse[i]   = press_q;
      assign release_pulse[i] = release_q;
      assign repeat_pulse[i]  = repeat_q;
   end

endmodule

// File: tb/tb_button_debounce.sv
module tb_button_debounce;

   localparam int K_PRESS = 0;
   localparam int K_REL   = 1;
   localparam int K_RPT   = 2;

   typedef struct {
      int cyc;
      int ch;
      int kind;
   } ev_t;

   logic       Clk;
   logic       Reset;
   logic [1:0] raw_a, raw_b;
   logic [1:0] level_a, press_a, release_a, repeat_a;
   logic [1:0] level_b, press_b, release_b, repeat_b;

   int  cyc = 0;
   int  n_tests = 0;
   int  n_fail = 0;
   int  press_cnt_b = 0;
   int  rel_cnt_b = 0;
   int  rpt_cnt_b = 0;
   ev_t sbq[$];

   button_debounce #(
      .NUM_BTN(2), .ACTIVE_LOW(1), .STABLE_CYCLES(4),
      .REPEAT_DELAY(10), .REPEAT_PERIOD(3)
   ) dut_a (
      .Clk(Clk), .Reset(Reset), .raw_in(raw_a),
      .level_out(level_a), .press_pulse(press_a),
      .release_pulse(release_a), .repeat_pulse(repeat_a)
   );

   button_debounce #(
      .NUM_BTN(2), .ACTIVE_LOW(1), .STABLE_CYCLES(4),
      .REPEAT_DELAY(0), .REPEAT_PERIOD(3)
   ) dut_b (
      .Clk(Clk), .Reset(Reset), .raw_in(raw_b),
      .level_out(level_b), .press_pulse(press_b),
      .release_pulse(release_b), .repeat_pulse(repeat_b)
   );

   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   always @(posedge Clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input int c, input int ch, input int k);
      ev_t e;
      e.cyc  = c;
      e.ch   = ch;
      e.kind = k;
      sbq.push_back(e);
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge Clk);
      #1;
   endtask

   // Every strobe from dut_a must match the next expected event in order.
   always @(negedge Clk) begin
      logic bitv;
      ev_t  e;
      if (!Reset) begin
         for (int ch = 0; ch < 2; ch++) begin
            for (int k = 0; k < 3; k++) begin
               bitv = (k == K_PRESS) ? press_a[ch] :
                      (k == K_REL)   ? release_a[ch] : repeat_a[ch];
               if (bitv) begin
                  n_tests++;
                  assert (sbq.size() > 0) else begin
                     n_fail++;
                     $error("FAIL unexpected_strobe observed cyc=%0d ch=%0d kind=%0d expected none", cyc, ch, k);
                  end
                  if (sbq.size() > 0) begin
                     e = sbq.pop_front();
                     chk("event_cycle", cyc, e.cyc);
                     chk("event_chan", ch, e.ch);
                     chk("event_kind", k, e.kind);
                  end
               end
            end
         end
         press_cnt_b += $countones(press_b);
         rel_cnt_b   += $countones(release_b);
         rpt_cnt_b   += $countones(repeat_b);
      end
   end

   initial begin
      int c, h;
      logic [7:0] bounce;
      logic [6:0] relpat;

      Reset = 1'b1;
      raw_a = 2'b11;
      raw_b = 2'b11;
      step(3);
      chk("rst_level_a", level_a, 2'b00);
      chk("rst_press_a", press_a, 2'b00);
      chk("rst_release_a", release_a, 2'b00);
      chk("rst_repeat_a", repeat_a, 2'b00);
      chk("rst_level_b", level_b, 2'b00);
      Reset = 1'b0;
      step(2);

      // 1: reset mid-hold, then re-confirm after reset release
      c = cyc;
      raw_a[0] = 1'b0;
      push(c + 4, 0, K_PRESS);
      step(6);
      chk("t1_held_level", level_a, 2'b01);
      Reset = 1'b1;
      #1;
      chk("t1_async_level", level_a, 2'b00);
      chk("t1_async_press", press_a, 2'b00);
      chk("t1_async_rel", release_a, 2'b00);
      chk("t1_async_rpt", repeat_a, 2'b00);
      step(2);
      Reset = 1'b0;
      push(cyc + 4, 0, K_PRESS);
      step(3);
      chk("t1_pre_level", level_a, 2'b00);
      chk("t1_pre_press", press_a, 2'b00);
      step(1);
      chk("t1_edge4_level", level_a, 2'b01);
      chk("t1_edge4_press", press_a, 2'b01);
      step(1);
      chk("t1_press_width", press_a, 2'b00);
      chk("t1_level_kept", level_a, 2'b01);

      // release so the bounce test starts from released
      raw_a[0] = 1'b1;
      push(cyc + 4, 0, K_REL);
      step(6);
      chk("t1_released", level_a, 2'b00);

      // 2: bounce rejection (raw 0 = pressed)
      bounce = 8'b0100_1000;   // applied LSB first: 0,0,0,1,0,0,1,0
      for (int i = 0; i < 8; i++) begin
         raw_a[0] = bounce[i];
         step(1);
         chk("t2_bounce_level", level_a[0], 1'b0);
         chk("t2_bounce_press", press_a[0], 1'b0);
      end
      raw_a[0] = 1'b1;
      step(2);
      chk("t2_still_released", level_a, 2'b00);
      raw_a[0] = 1'b0;
      push(cyc + 4, 0, K_PRESS);
      step(6);
      chk("t2_pressed", level_a, 2'b01);

      // 3: release confirm with a single glitch back to pressed
      relpat = 7'b111_1011;    // applied LSB first: 1,1,0,1,1,1,1
      push(cyc + 7, 0, K_REL);
      for (int i = 0; i < 7; i++) begin
         raw_a[0] = relpat[i];
         step(1);
         chk("t3_level", level_a[0], (i < 6) ? 1'b1 : 1'b0);
      end
      step(4);

      // 4: auto-repeat on key1
      c = cyc;
      raw_a[1] = 1'b0;
      push(c + 4, 1, K_PRESS);
      for (int r = 10; r <= 28; r += 3) push(c + 4 + r, 1, K_RPT);
      push(c + 4 + 33, 1, K_REL);
      step(33);
      chk("t4_held_level", level_a, 2'b10);
      raw_a[1] = 1'b1;
      step(12);
      chk("t4_released", level_a, 2'b00);

      // 5: independence, presses staggered by two cycles
      h = cyc;
      raw_a[0] = 1'b0;
      push(h + 4, 0, K_PRESS);
      step(2);
      raw_a[1] = 1'b0;
      push(h + 6, 1, K_PRESS);
      step(8);
      chk("t5_both_held", level_a, 2'b11);
      raw_a[0] = 1'b1;
      push(h + 14, 0, K_REL);
      step(2);
      raw_a[1] = 1'b1;
      push(h + 16, 1, K_REL);
      step(8);
      chk("t5_both_released", level_a, 2'b00);

      // 6: repeat disabled, long hold on dut_b
      raw_b[0] = 1'b0;
      for (int i = 0; i < 100; i++) begin
         step(1);
         chk("t6_no_repeat", repeat_b, 2'b00);
      end
      chk("t6_held_level", level_b, 2'b01);
      raw_b[0] = 1'b1;
      step(10);
      chk("t6_released_level", level_b, 2'b00);
      chk("t6_press_count", press_cnt_b, 1);
      chk("t6_release_count", rel_cnt_b, 1);
      chk("t6_repeat_count", rpt_cnt_b, 0);

      chk("sb_empty", sbq.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
